// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one byte per frame and
// serializes it as 8N1 on txd, LSB first, CLK_DIV clocks per bit.
module fifo_uart_tx #(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       empty,
    input  logic [7:0] rdata,
    output logic       ren,
    output logic       txd,
    output logic       busy,
    output logic       ok
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          ok_q, ok_d;
    logic          wrap;
    logic [DW-1:0] div_inc;

    assign wrap    = (div_q == DIV_LAST);
    assign div_inc = wrap ? '0 : div_q + 1'b1;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        ok_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d = rdata;
                bit_d   = '0;
                div_d   = '0;
                txd_d   = 1'b0;
                state_d = START;
            end
            START: begin
                div_d = div_inc;
                if (wrap) begin
                    txd_d   = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                div_d = div_inc;
                if (wrap) begin
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        // txd is registered, so present the next bit now
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end
            end
            STOP: begin
                div_d = div_inc;
                if (wrap) begin
                    ok_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ok_q    <= ok_d;
        end
    end

    assign ren  = (state_q == FETCH);
    assign busy = (state_q != IDLE);
    assign txd  = txd_q;
    assign ok   = ok_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one instance at CLK_DIV=4 and
// one at CLK_DIV=8, each fed by a small FIFO model.
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n, rst8_n;
    logic       start4, start8;
    logic       empty4, empty8;
    logic [7:0] rdata4, rdata8;
    logic       ren4, ren8, txd4, txd8;
    logic       busy4, busy8, ok4, ok8;

    logic [7:0] mem4 [16];
    logic [7:0] mem8 [16];
    int         rd4 = 0, wr4 = 0, rd8 = 0, wr8 = 0;

    logic       sel = 1'b0;
    logic       s_ren, s_txd, s_busy, s_ok;
    int         cyc = 0;
    int         c0_cyc = 0;
    int         c0_prev;
    int         n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    fifo_uart_tx #(.CLK_DIV(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .empty (empty4),
        .rdata (rdata4),
        .ren   (ren4),
        .txd   (txd4),
        .busy  (busy4),
        .ok    (ok4)
    );

    fifo_uart_tx #(.CLK_DIV(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst8_n),
        .start (start8),
        .empty (empty8),
        .rdata (rdata8),
        .ren   (ren8),
        .txd   (txd8),
        .busy  (busy8),
        .ok    (ok8)
    );

    assign empty4 = (rd4 == wr4);
    assign empty8 = (rd8 == wr8);

    always @(posedge clk) begin
        if (ren4) begin
            rdata4 <= mem4[rd4 % 16];
            rd4    <= rd4 + 1;
        end
        if (ren8) begin
            rdata8 <= mem8[rd8 % 16];
            rd8    <= rd8 + 1;
        end
    end

    assign s_ren  = sel ? ren8  : ren4;
    assign s_txd  = sel ? txd8  : txd4;
    assign s_busy = sel ? busy8 : busy4;
    assign s_ok   = sel ? ok8   : ok4;

    task automatic chk(input string tag,
                       input logic [79:0] got,
                       input logic [79:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic push4(input logic [7:0] b);
        mem4[wr4 % 16] = b;
        wr4++;
    endtask

    task automatic push8(input logic [7:0] b);
        mem8[wr8 % 16] = b;
        wr8++;
    endtask

    task automatic quiet(input int n,
                         output logic ren_any,
                         output logic busy_any,
                         output logic ok_any,
                         output logic txd_all);
        ren_any  = 1'b0;
        busy_any = 1'b0;
        ok_any   = 1'b0;
        txd_all  = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ren_any  |= s_ren;
            busy_any |= s_busy;
            ok_any   |= s_ok;
            txd_all  &= s_txd;
        end
    endtask

    // Waits for ren, then checks one full frame through the ok cycle.
    task automatic watch(input logic [7:0] b,
                         input int drop_k,
                         input int exp_lat,
                         input string tag);
        int          d;
        int          lat;
        logic [79:0] obs, exp;
        logic [9:0]  fr;
        logic        busy_all, ok_any, ren_any;
        d   = sel ? 8 : 4;
        fr  = {1'b1, b, 1'b0};
        lat = 0;
        obs = '0;
        exp = '0;
        do begin
            @(negedge clk);
            lat++;
        end while (!s_ren && lat < 200);
        if (!s_ren) begin
            chk({tag, " ren timeout"}, 80'd0, 80'd1);
            return;
        end
        c0_cyc = cyc;
        chk({tag, " ren lat"}, 80'(lat), 80'(exp_lat));
        chk({tag, " c0 busy"}, 80'(s_busy), 80'd1);
        chk({tag, " c0 txd"}, 80'(s_txd), 80'd1);
        @(negedge clk);
        chk({tag, " c1 txd"}, 80'(s_txd), 80'd1);
        chk({tag, " c1 ren"}, 80'(s_ren), 80'd0);
        busy_all = 1'b1;
        ok_any   = 1'b0;
        ren_any  = 1'b0;
        for (int k = 0; k < 10 * d; k++) begin
            @(negedge clk);
            if (k == drop_k) begin
                if (sel) start8 = 1'b0;
                else     start4 = 1'b0;
            end
            obs[k]    = s_txd;
            exp[k]    = fr[k / d];
            busy_all &= s_busy;
            ok_any   |= s_ok;
            ren_any  |= s_ren;
        end
        chk({tag, " frame"}, obs, exp);
        chk({tag, " busy in frame"}, 80'(busy_all), 80'd1);
        chk({tag, " ok early"}, 80'(ok_any), 80'd0);
        chk({tag, " ren in frame"}, 80'(ren_any), 80'd0);
        @(negedge clk);
        chk({tag, " ok"}, 80'(s_ok), 80'd1);
        chk({tag, " busy at ok"}, 80'(s_busy), 80'd0);
        chk({tag, " txd at ok"}, 80'(s_txd), 80'd1);
    endtask

    initial begin
        logic r_any, b_any, o_any, t_all;
        int   lat;

        start4 = 1'b0;
        start8 = 1'b0;
        rst_n  = 1'b0;
        rst8_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst txd4", 80'(txd4), 80'd1);
        chk("rst ren4", 80'(ren4), 80'd0);
        chk("rst ok4", 80'(ok4), 80'd0);
        chk("rst busy4", 80'(busy4), 80'd0);
        chk("rst txd8", 80'(txd8), 80'd1);
        chk("rst busy8", 80'(busy8), 80'd0);
        rst_n  = 1'b1;
        rst8_n = 1'b1;
        @(negedge clk);

        push4(8'hA5);
        start4 = 1'b1;
        watch(8'hA5, -1, 1, "a5");
        start4 = 1'b0;
        quiet(10, r_any, b_any, o_any, t_all);
        chk("a5 single ren", 80'(r_any), 80'd0);

        push4(8'h00);
        push4(8'hFF);
        start4 = 1'b1;
        watch(8'h00, -1, 1, "b2b0");
        c0_prev = c0_cyc;
        watch(8'hFF, -1, 1, "b2b1");
        chk("b2b period", 80'(c0_cyc - c0_prev), 80'd43);

        quiet(100, r_any, b_any, o_any, t_all);
        chk("empty ren", 80'(r_any), 80'd0);
        chk("empty busy", 80'(b_any), 80'd0);
        chk("empty ok", 80'(o_any), 80'd0);
        chk("empty txd", 80'(t_all), 80'd1);

        start4 = 1'b0;
        push4(8'h5A);
        quiet(100, r_any, b_any, o_any, t_all);
        chk("nostart ren", 80'(r_any), 80'd0);
        chk("nostart busy", 80'(b_any), 80'd0);
        chk("nostart txd", 80'(t_all), 80'd1);
        start4 = 1'b1;
        watch(8'h5A, -1, 1, "start5a");
        start4 = 1'b0;

        push4(8'h3C);
        push4(8'h77);
        start4 = 1'b1;
        watch(8'h3C, 12, 1, "drop3c");
        quiet(60, r_any, b_any, o_any, t_all);
        chk("drop no ren", 80'(r_any), 80'd0);
        chk("drop no busy", 80'(b_any), 80'd0);

        sel = 1'b1;
        push8(8'hC3);
        start8 = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ren8 && lat < 200);
        chk("c3 ren lat", 80'(lat), 80'd1);
        repeat (36) @(negedge clk);
        chk("c3 bit3", 80'(txd8), 80'd0);
        #2 rst8_n = 1'b0;
        #1;
        chk("mid rst txd", 80'(txd8), 80'd1);
        chk("mid rst busy", 80'(busy8), 80'd0);
        chk("mid rst ren", 80'(ren8), 80'd0);
        chk("mid rst ok", 80'(ok8), 80'd0);
        quiet(5, r_any, b_any, o_any, t_all);
        chk("in rst ok", 80'(o_any), 80'd0);
        chk("in rst busy", 80'(b_any), 80'd0);
        push8(8'h96);
        rst8_n = 1'b1;
        watch(8'h96, -1, 1, "post rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
